otp_stream_ctrl: RTL and testbench
==================================

OTP_STREAM_CTRL -- requirements
Module: otp_stream_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port start, input, 1, begin one message; sampled only in IDLE.
REQ-004 SHALL have port abort, input, 1, synchronous cancel of the current message.
REQ-005 SHALL have port seed, input, 8, PRNG seed; latched on an accepted start.
REQ-006 SHALL have port msg_len, input, 8, message length in bytes; latched on an accepted start; 0 = empty message.
REQ-007 SHALL have ports in_valid (input, 1), in_data (input, 8) and in_ready (output, 1), forming the plaintext byte handshake.
REQ-008 SHALL have ports out_valid (output, 1), out_data (output, 8) and out_ready (input, 1), forming the ciphertext byte handshake.
REQ-009 SHALL have ports prng_load (output, 1), prng_seed (output, 8) and prng_step (output, 1), driving the PRNG's load, seed and advance inputs.
REQ-010 SHALL have port prng_out, input, 8, current PRNG keystream byte.
REQ-011 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse) and byte_cnt (output, 8, bytes accepted in the current message).

Function
REQ-012 SHALL implement the state machine IDLE -> LOAD -> PRIME -> RUN -> DRAIN -> DONE -> IDLE.
REQ-013 IDLE: busy=0, in_ready=0; start=1 with msg_len!=0 latches seed/msg_len, clears byte_cnt -> LOAD.
REQ-014 IDLE: start=1 with msg_len==0 pulses done next cycle, stays IDLE, never asserts prng_load.
REQ-015 LOAD: prng_load=1, prng_seed=latched seed for exactly one cycle -> PRIME.
REQ-016 PRIME: prng_step=1 for exactly one cycle (seed byte never used as key) -> RUN.
REQ-017 RUN: in_ready = !out_valid || out_ready (one-entry output register, full throughput).
REQ-018 RUN: on accept (in_valid && in_ready), out_data <= in_data XOR prng_out, out_valid <= 1, and byte_cnt increments, all at the next edge; prng_step=1 in that same cycle only.
REQ-019 prng_step SHALL be 0 in every cycle without an accept in RUN (keystream never skips or repeats).
REQ-020 out_valid SHALL clear on out_valid && out_ready unless a new byte is accepted in the same cycle (simultaneous pop+push keeps out_valid=1 with the new data).
REQ-021 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 On the accept that makes byte_cnt equal the latched msg_len -> DRAIN; in_ready=0 from then on.
REQ-023 Every msg_len value 1..255 SHALL be supported; byte_cnt SHALL never wrap within a message.
REQ-024 DRAIN: wait until out_valid=0 (last byte consumed) -> DONE.
REQ-025 DONE: done=1 for one cycle, busy=0 -> IDLE; byte_cnt holds its final value until the next accepted start.
REQ-026 busy SHALL be 1 in LOAD, PRIME, RUN and DRAIN.
REQ-027 start while busy SHALL be ignored; latched seed and msg_len SHALL not change.
REQ-028 abort=1 in any non-IDLE state -> IDLE next edge: out_valid=0, no done pulse, byte_cnt held; abort SHALL take priority over an accept in the same cycle; abort in IDLE SHALL have no effect.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, with out_valid, in_ready, prng_load, prng_step, busy, done = 0, and out_data, byte_cnt, prng_seed, latched seed and latched msg_len = 0.
REQ-030 Reset mid-message SHALL discard the message; after release the block waits for a fresh start.

Verification
REQ-031 Bench SHALL cover: start, seed=8'd22, msg_len=3 -> prng_load one cycle with prng_seed=22, then one PRIME step, then busy=1.
REQ-032 Bench SHALL cover: stub prng_out=8'hA5, in_data=8'h3C accepted -> out_data=8'h99, out_valid=1 one cycle later.
REQ-033 Bench SHALL cover: out_ready=0 for 4 cycles with in_valid held high -> exactly one byte buffered, in_ready=0, prng_step=0, out_data stable.
REQ-034 Bench SHALL cover: msg_len=2, continuous valid/ready -> 2 outputs back-to-back, exactly 3 prng_step pulses total (1 prime + 2), then one done pulse, byte_cnt=2.
REQ-035 Bench SHALL cover: msg_len=0 start -> done pulse, prng_load never asserted; abort after 1 byte of msg_len=5 -> IDLE, out_valid=0, no done, byte_cnt=1.
REQ-036 Bench SHALL cover: reset=0 asserted mid-RUN -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/otp_stream_ctrl.sv
// One-time-pad stream controller: seeds and primes an external PRNG, then XORs each
// accepted plaintext byte with the current keystream byte into a one-entry output register.
module otp_stream_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  input  logic [7:0] msg_len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       prng_load,
  output logic [7:0] prng_seed,
  output logic       prng_step,
  input  logic [7:0] prng_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPrime,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e     state_q;
  logic [7:0] seed_q;
  logic [7:0] len_q;
  logic [7:0] out_data_q;
  logic [7:0] byte_cnt_q;
  logic       out_valid_q;
  logic       prng_load_q;
  logic       busy_q;
  logic       done_q;

  logic accept;
  logic last_byte;

  assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
  // Abort wins over a same-cycle accept, so the keystream is not advanced either.
  assign accept    = in_ready && in_valid && !abort;
  assign last_byte = (byte_cnt_q + 8'd1) == len_q;
  assign prng_step = accept || ((state_q == StPrime) && !abort);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign prng_load = prng_load_q;
  assign prng_seed = seed_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign byte_cnt  = byte_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      seed_q      <= 8'd0;
      len_q       <= 8'd0;
      out_data_q  <= 8'd0;
      byte_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      prng_load_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      prng_load_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (msg_len != 8'd0) begin
                seed_q      <= seed;
                len_q       <= msg_len;
                byte_cnt_q  <= 8'd0;
                prng_load_q <= 1'b1;
                busy_q      <= 1'b1;
                state_q     <= StLoad;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          StLoad:  state_q <= StPrime;
          StPrime: state_q <= StRun;
          StRun: begin
            if (accept) begin
              out_data_q  <= in_data ^ prng_out;
              out_valid_q <= 1'b1;
              byte_cnt_q  <= byte_cnt_q + 8'd1;
              if (last_byte) begin
                state_q <= StDrain;
              end
            end
          end
          StDrain: begin
            if (!out_valid_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_otp_stream_ctrl.sv
// Bench for otp_stream_ctrl: a stub PRNG plus a keystream reference model that derives
// each byte's key from the seed by stepping the PRNG function (index + 1) times.
module tb_otp_stream_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] seed = 8'd0;
  logic [7:0] msg_len = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b0;
  logic [7:0] prng_out;
  logic       in_ready, out_valid, prng_load, prng_step, busy, done;
  logic [7:0] out_data, prng_seed, byte_cnt;

  int n_cmp = 0;
  int n_err = 0;

  otp_stream_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .msg_len   (msg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .prng_load (prng_load),
    .prng_seed (prng_seed),
    .prng_step (prng_step),
    .prng_out  (prng_out),
    .busy      (busy),
    .done      (done),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] prng_next(input logic [7:0] s);
    return s * 8'd29 + 8'd71;
  endfunction

  // Key for byte idx: load gives seed, the prime step discards it, byte i uses step i+1.
  function automatic logic [7:0] key_at(input logic [7:0] s, input int idx);
    logic [7:0] k;
    k = s;
    for (int i = 0; i <= idx; i++) k = prng_next(k);
    return k;
  endfunction

  // Stub PRNG device, optionally overridden by a fixed keystream byte.
  logic [7:0] prng_st = 8'd0;
  logic       fixed_en = 1'b0;
  logic [7:0] fixed_val = 8'd0;
  always @(posedge clk) begin
    if (prng_load) prng_st <= prng_seed;
    else if (prng_step) prng_st <= prng_next(prng_st);
  end
  assign prng_out = fixed_en ? fixed_val : prng_st;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, prng_load, prng_step, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000",
               {out_valid, in_ready, prng_load, prng_step, busy, done});
    end
    n_cmp++;
    if ({out_data, byte_cnt, prng_seed} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 000000", {out_data, byte_cnt, prng_seed});
    end
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, prng_load, prng_step, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL idle_flags: got %b want 000000",
               {out_valid, in_ready, prng_load, prng_step, busy, done});
    end
  endtask

  task automatic test_load_prime();
    tick();
    start = 1'b1; seed = 8'd22; msg_len = 8'd3; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (prng_load !== 1'b0) begin n_err++; $display("FAIL idle_load: got %b want 0", prng_load); end
    tick();
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({prng_load, busy, prng_step} !== 3'b110) begin
      n_err++; $display("FAIL load_flags: got %b want 110", {prng_load, busy, prng_step});
    end
    n_cmp++;
    if (prng_seed !== 8'd22) begin n_err++; $display("FAIL load_seed: got %0d want 22", prng_seed); end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({prng_load, busy, prng_step} !== 3'b011) begin
      n_err++; $display("FAIL prime_flags: got %b want 011", {prng_load, busy, prng_step});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({prng_load, busy, prng_step, in_ready} !== 4'b0101) begin
      n_err++;
      $display("FAIL run_flags: got %b want 0101", {prng_load, busy, prng_step, in_ready});
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL abort_idle: got %b want 000", {busy, done, in_ready});
    end
  endtask

  task automatic test_xor_fixed();
    bit seen;
    fixed_en = 1'b1; fixed_val = 8'hA5;
    tick();
    start = 1'b1; seed = 8'($urandom); msg_len = 8'd1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, prng_step} !== 2'b11) begin
      n_err++; $display("FAIL xor_accept: got %b want 11", {in_ready, prng_step});
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      n_err++; $display("FAIL xor_out: got v=%b d=%h want v=1 d=99", out_valid, out_data);
    end
    n_cmp++;
    if (byte_cnt !== 8'd1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL xor_cnt: got cnt=%0d rdy=%b want 1 0", byte_cnt, in_ready);
    end
    tick();
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || busy !== 1'b0 || byte_cnt !== 8'd1) begin
      n_err++; $display("FAIL xor_done: got done=%b busy=%b cnt=%0d want 1 0 1", seen, busy, byte_cnt);
    end
    fixed_en = 1'b0;
  endtask

  // Runs one message with random handshakes and random ignored starts; checks every
  // ciphertext byte, hold stability, step/load counts and the single done pulse.
  task automatic run_message(input logic [7:0] s, input logic [7:0] l, input int vp,
                             input int rp, input bit stall, output int steps, output int pops,
                             output int first_pop, output int last_pop);
    logic [7:0] exp[$];
    logic [7:0] want, hold_data;
    int acc, dones, loads, stall_cnt;
    bit stalling, hold;
    acc = 0; dones = 0; loads = 0; stall_cnt = 0; stalling = 0; hold = 0;
    steps = 0; pops = 0; first_pop = -1; last_pop = -1;
    tick();
    start = 1'b1; seed = s; msg_len = l; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== hold_data) begin
          n_err++; $display("FAIL hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, hold_data);
        end
      end
      if (stalling && exp.size() > 0) begin
        n_cmp++;
        if ({out_valid, in_ready, prng_step} !== 3'b100 || out_data !== exp[0] ||
            byte_cnt !== 8'd1) begin
          n_err++;
          $display("FAIL stall: got vrs=%b d=%h cnt=%0d want 100 d=%h cnt=1",
                   {out_valid, in_ready, prng_step}, out_data, byte_cnt, exp[0]);
        end
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (prng_step) steps++;
      if (prng_load) loads++;
      if (out_valid && out_ready) begin
        want = (exp.size() > 0) ? exp.pop_front() : ~out_data;
        n_cmp++;
        if (out_data !== want) begin
          n_err++; $display("FAIL cipher[%0d]: got %h want %h", pops, out_data, want);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
      if (in_valid && in_ready) begin
        exp.push_back(in_data ^ key_at(s, acc));
        acc++;
      end
      if (done) begin
        dones++;
        break;
      end
      tick();
      start = 1'($urandom); seed = 8'($urandom); msg_len = 8'($urandom);
      in_data = 8'($urandom);
      if (stall && acc == 1 && stall_cnt < 4) begin
        in_valid = 1'b1; out_ready = 1'b0; stall_cnt++; stalling = 1;
      end else begin
        in_valid = int'($urandom_range(99)) < vp;
        out_ready = int'($urandom_range(99)) < rp;
        stalling = 0;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL msg_done: got %0d pulses want 1 (timeout)", dones); end
    n_cmp++;
    if (byte_cnt !== l || acc != int'(l) || pops != int'(l)) begin
      n_err++;
      $display("FAIL msg_count: got cnt=%0d acc=%0d pops=%0d want %0d", byte_cnt, acc, pops, l);
    end
    n_cmp++;
    if (steps != int'(l) + 1 || loads != 1) begin
      n_err++; $display("FAIL msg_prng: got steps=%0d loads=%0d want %0d 1", steps, loads, l + 1);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL msg_after: got done/busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_backpressure();
    int st, pp, fp, lp;
    run_message(8'($urandom), 8'd3, 100, 100, 1'b1, st, pp, fp, lp);
  endtask

  task automatic test_back_to_back();
    int st, pp, fp, lp;
    run_message(8'($urandom), 8'd2, 100, 100, 1'b0, st, pp, fp, lp);
    n_cmp++;
    if (st != 3 || pp != 2 || lp - fp != 1) begin
      n_err++; $display("FAIL b2b: got steps=%0d pops=%0d gap=%0d want 3 2 1", st, pp, lp - fp);
    end
  endtask

  task automatic test_random();
    int st, pp, fp, lp;
    logic [7:0] l;
    for (int m = 0; m < 12; m++) begin
      l = (m == 0) ? 8'd255 : (m == 1) ? 8'd1 : 8'($urandom_range(40, 1));
      run_message(8'($urandom), l, int'($urandom_range(100, 40)), int'($urandom_range(100, 40)),
                  1'b0, st, pp, fp, lp);
    end
  endtask

  task automatic test_zero_len();
    tick();
    start = 1'b1; seed = 8'($urandom); msg_len = 8'd0;
    @(negedge clk);
    n_cmp++;
    if (prng_load !== 1'b0) begin n_err++; $display("FAIL zero_load0: got %b want 0", prng_load); end
    tick();
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({done, busy, prng_load} !== 3'b100) begin
      n_err++; $display("FAIL zero_done: got %b want 100", {done, busy, prng_load});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if ({done, busy, prng_load} !== 3'b000) begin
        n_err++; $display("FAIL zero_after: got %b want 000", {done, busy, prng_load});
      end
    end
  endtask

  task automatic test_abort();
    tick();
    start = 1'b1; seed = 8'($urandom); msg_len = 8'd5; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_acc: got %b want 1", in_ready); end
    tick();
    abort = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, prng_step} !== 2'b10) begin
      n_err++; $display("FAIL abort_step: got %b want 10", {out_valid, prng_step});
    end
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, out_valid, in_ready, done} !== 4'b0000 || byte_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL abort_state: got %b cnt=%0d want 0000 cnt=1",
               {busy, out_valid, in_ready, done}, byte_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_err++; $display("FAIL abort_nodone: got %b want 00", {done, busy});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    start = 1'b1; seed = 8'($urandom); msg_len = 8'd4; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 8'($urandom);
    tick();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, busy} !== 2'b11 || byte_cnt !== 8'd1) begin
      n_err++; $display("FAIL rst_pre: got %b cnt=%0d want 11 cnt=1", {out_valid, busy}, byte_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, prng_load, prng_step, busy, done} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_async_flags: got %b want 000000",
               {out_valid, in_ready, prng_load, prng_step, busy, done});
    end
    n_cmp++;
    if ({out_data, byte_cnt, prng_seed} !== 24'h0) begin
      n_err++; $display("FAIL rst_async_data: got %h want 000000", {out_data, byte_cnt, prng_seed});
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if ({busy, out_valid, in_ready, prng_load} !== 4'b0000) begin
        n_err++;
        $display("FAIL rst_after: got %b want 0000", {busy, out_valid, in_ready, prng_load});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_prime();
    test_xor_fixed();
    test_backpressure();
    test_back_to_back();
    test_zero_len();
    test_abort();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
